// File: rtl/vpp_dc_extractor_pkg.sv
// rtl/vpp_dc_extractor_pkg.sv - shared widths, limits, reload constants and FSM type
// Optional feature macro in this slice: VPP_AVG_EN
package vpp_dc_extractor_pkg;

   localparam int SAMPLE_W = 8;

   localparam logic signed [SAMPLE_W:0] SAT_MAX = 9'sd127;
   localparam logic signed [SAMPLE_W:0] SAT_MIN = -9'sd128;

   localparam logic [SAMPLE_W-1:0] MIN_RELOAD = 8'd255;
   localparam logic [SAMPLE_W-1:0] MAX_RELOAD = 8'd0;

   typedef enum logic {
      WARMUP = 1'b0,
      RUN    = 1'b1
   } state_t;

   function automatic logic [SAMPLE_W-1:0] sat8(input logic signed [SAMPLE_W:0] d);
      if (d > SAT_MAX)
         return SAT_MAX[SAMPLE_W-1:0];
      else if (d < SAT_MIN)
         return SAT_MIN[SAMPLE_W-1:0];
      else
         return d[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/vpp_dc_extractor_minmax_tracker.sv
// rtl/vpp_dc_extractor_minmax_tracker.sv - running min/max of valid samples
// min/max outputs already include the sample presented this cycle.
module minmax_tracker
   import vpp_dc_extractor_pkg::*;
(
   input  logic                sample_clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                valid,
   input  logic                restart,
   output logic [SAMPLE_W-1:0] min,
   output logic [SAMPLE_W-1:0] max
);

   logic [SAMPLE_W-1:0] min_q;
   logic [SAMPLE_W-1:0] max_q;

   assign min = (valid && (sample < min_q)) ? sample : min_q;
   assign max = (valid && (sample > max_q)) ? sample : max_q;

   // restart accompanies the last sample of a window, so the next sample seeds both
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q <= MIN_RELOAD;
         max_q <= MAX_RELOAD;
      end else if (valid) begin
         if (restart) begin
            min_q <= MIN_RELOAD;
            max_q <= MAX_RELOAD;
         end else begin
            min_q <= min;
            max_q <= max;
         end
      end
   end

endmodule

// File: rtl/vpp_dc_extractor.sv
// rtl/vpp_dc_extractor.sv - windowed Vpp / DC offset measurement and DC removal
// Define VPP_AVG_EN to report vpp as the mean of the last four window values.
module vpp_dc_extractor
   import vpp_dc_extractor_pkg::*;
#(
   parameter int WINDOW_POINTS = 64,
   parameter int LOG2_WINDOW   = 6,
   parameter int MIN_VPP       = 8
) (
   input  logic                       sample_clk,
   input  logic                       rst_n,
   input  logic [SAMPLE_W-1:0]        adc_data,
   input  logic                       adc_valid,
   output logic signed [SAMPLE_W-1:0] signal_dc_removed,
   output logic                       signal_valid,
   output logic [SAMPLE_W-1:0]        vpp,
   output logic [SAMPLE_W-1:0]        dc_offset,
   output logic                       window_done,
   output logic                       stats_valid,
   output logic                       signal_present
);

   state_t                  state;
   logic [LOG2_WINDOW-1:0]  count;
   logic                    window_end;
   logic [SAMPLE_W-1:0]     cur_min;
   logic [SAMPLE_W-1:0]     cur_max;
   logic [SAMPLE_W-1:0]     raw_vpp;
   logic [SAMPLE_W:0]       mm_sum;
   logic [SAMPLE_W-1:0]     vpp_next;
   logic signed [SAMPLE_W:0] diff;

   assign window_end = adc_valid && (count == LOG2_WINDOW'(WINDOW_POINTS - 1));
   assign raw_vpp    = cur_max - cur_min;
   assign mm_sum     = {1'b0, cur_max} + {1'b0, cur_min};
   assign diff       = $signed({1'b0, adc_data}) - $signed({1'b0, dc_offset});
   assign stats_valid = (state == RUN);

   minmax_tracker u_minmax (
      .sample_clk (sample_clk),
      .rst_n      (rst_n),
      .sample     (adc_data),
      .valid      (adc_valid),
      .restart    (window_end),
      .min        (cur_min),
      .max        (cur_max)
   );

`ifdef VPP_AVG_EN
   logic [SAMPLE_W-1:0] hist [3];
   logic [SAMPLE_W+1:0] avg_sum;

   assign avg_sum  = 10'(raw_vpp) + 10'(hist[0]) + 10'(hist[1]) + 10'(hist[2]);
   assign vpp_next = avg_sum[SAMPLE_W+1:2];

   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         hist[0] <= '0;
         hist[1] <= '0;
         hist[2] <= '0;
      end else if (window_end) begin
         hist[0] <= raw_vpp;
         hist[1] <= hist[0];
         hist[2] <= hist[1];
      end
   end
`else
   assign vpp_next = raw_vpp;
`endif

   // dc_offset read here is the pre-update value, so a window-end sample uses the old offset
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= WARMUP;
         count             <= '0;
         signal_dc_removed <= '0;
         signal_valid      <= 1'b0;
         vpp               <= '0;
         dc_offset         <= '0;
         window_done       <= 1'b0;
         signal_present    <= 1'b0;
      end else begin
         window_done  <= window_end;
         signal_valid <= adc_valid && (state == RUN);
         if (adc_valid) begin
            if (state == RUN)
               signal_dc_removed <= sat8(diff);
            if (window_end) begin
               count          <= '0;
               vpp            <= vpp_next;
               dc_offset      <= mm_sum[SAMPLE_W:1];
               signal_present <= (raw_vpp >= SAMPLE_W'(MIN_VPP));
               state          <= RUN;
            end else begin
               count <= count + LOG2_WINDOW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_vpp_dc_extractor.sv
// tb/tb_vpp_dc_extractor.sv - scoreboard bench for vpp_dc_extractor
// Build with +define+VPP_AVG_EN to exercise the averaged-vpp configuration.
module tb_vpp_dc_extractor;

   typedef struct packed {
      logic [7:0] vpp;
      logic [7:0] dc;
      logic       present;
   } win_t;

   logic              sample_clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        adc_data = '0;
   logic              adc_valid = 1'b0;
   logic signed [7:0] signal_dc_removed;
   logic              signal_valid;
   logic [7:0]        vpp;
   logic [7:0]        dc_offset;
   logic              window_done;
   logic              stats_valid;
   logic              signal_present;

   int   total = 0;
   int   bad = 0;
   int   sig_q [$];
   win_t win_q [$];
   int   vhist [3];

   vpp_dc_extractor dut (
      .sample_clk        (sample_clk),
      .rst_n             (rst_n),
      .adc_data          (adc_data),
      .adc_valid         (adc_valid),
      .signal_dc_removed (signal_dc_removed),
      .signal_valid      (signal_valid),
      .vpp               (vpp),
      .dc_offset         (dc_offset),
      .window_done       (window_done),
      .stats_valid       (stats_valid),
      .signal_present    (signal_present)
   );

   always #5 sample_clk = ~sample_clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // expected vpp for a window whose raw peak-to-peak is raw
   function automatic int expect_vpp(input int raw);
      int r;
`ifdef VPP_AVG_EN
      r = (raw + vhist[0] + vhist[1] + vhist[2]) >> 2;
`else
      r = raw;
`endif
      vhist[2] = vhist[1];
      vhist[1] = vhist[0];
      vhist[0] = raw;
      return r;
   endfunction

   task automatic push_win(input int raw, input int dc, input bit present);
      win_t w;
      w.vpp     = 8'(expect_vpp(raw));
      w.dc      = 8'(dc);
      w.present = present;
      win_q.push_back(w);
   endtask

   task automatic send(input int v, input bit has_exp, input int exp);
      if (has_exp)
         sig_q.push_back(exp);
      adc_data  = 8'(v);
      adc_valid = 1'b1;
      @(posedge sample_clk);
      #1;
      adc_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge sample_clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_sig"}, int'(signal_dc_removed), 0);
      check({tag, "_sigv"}, int'(signal_valid), 0);
      check({tag, "_vpp"}, int'(vpp), 0);
      check({tag, "_dc"}, int'(dc_offset), 0);
      check({tag, "_wdone"}, int'(window_done), 0);
      check({tag, "_stats"}, int'(stats_valid), 0);
      check({tag, "_present"}, int'(signal_present), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_cleared("reset");
      vhist = '{0, 0, 0};
      @(posedge sample_clk);
      #1;
      rst_n = 1'b1;
   endtask

   always @(negedge sample_clk) begin
      if (rst_n) begin
         if (signal_valid) begin
            if (sig_q.size() == 0)
               check("unexpected_signal_valid", 1, 0);
            else
               check("signal_dc_removed", int'(signal_dc_removed), sig_q.pop_front());
         end
         if (window_done) begin
            if (win_q.size() == 0)
               check("unexpected_window_done", 1, 0);
            else begin
               win_t w;
               w = win_q.pop_front();
               check("win_vpp", int'(vpp), int'(w.vpp));
               check("win_dc_offset", int'(dc_offset), int'(w.dc));
               check("win_present", int'(signal_present), int'(w.present));
               check("win_stats_valid", int'(stats_valid), 1);
            end
         end
      end
   end

   initial begin
      vhist = '{0, 0, 0};
      #2;
      check_cleared("init");
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // constant 128 input, warmup window
      for (int i = 0; i < 64; i++) begin
         if (i == 63) push_win(0, 128, 1'b0);
         send(128, 1'b0, 0);
      end
      idle(1);
      check("stats_after_first", int'(stats_valid), 1);

      // alternating 28/228 for two windows
      for (int i = 0; i < 128; i++) begin
         if (i % 64 == 63) push_win(200, 128, 1'b1);
         send((i % 2) ? 228 : 28, 1'b1, (i % 2) ? 100 : -100);
      end

      // low window 0..20 then high-side saturation
      for (int i = 0; i < 64; i++) begin
         if (i == 63) push_win(20, 10, 1'b1);
         send(i % 21, 1'b1, (i % 21) - 128);
      end
      send(255, 1'b1, 127);
      for (int i = 1; i < 64; i++) begin
         if (i == 63) push_win(20, 245, 1'b1);
         send(235 + (i % 21), 1'b1, 127);
      end
      send(0, 1'b1, -128);
      idle(2);
      do_reset();

      // one valid sample in three; window_done only after the 64th
      for (int i = 0; i < 64; i++) begin
         if (i == 63) push_win(10, 105, 1'b1);
         send((i % 2) ? 110 : 100, 1'b0, 0);
         check("sparse_wdone", int'(window_done), (i == 63) ? 1 : 0);
         idle(1);
         check("sparse_gap_wdone", int'(window_done), 0);
         if (i != 63) idle(1);
      end

      // reset 30 samples into the second window
      for (int i = 0; i < 30; i++)
         send(120, 1'b1, 15);
      idle(1);
      do_reset();
      for (int i = 0; i < 64; i++) begin
         if (i == 63) push_win(0, 50, 1'b0);
         send(50, 1'b0, 0);
         check("post_reset_wdone", int'(window_done), (i == 63) ? 1 : 0);
      end
      idle(1);
      check("post_reset_stats", int'(stats_valid), 1);

      // window vpp sequence 100,100,200,200
      idle(1);
      do_reset();
      for (int i = 0; i < 64; i++) begin
         if (i == 63) push_win(100, 100, 1'b1);
         send((i % 2) ? 150 : 50, 1'b0, 0);
      end
      for (int i = 0; i < 64; i++) begin
         if (i == 63) push_win(100, 100, 1'b1);
         send((i % 2) ? 150 : 50, 1'b1, (i % 2) ? 50 : -50);
      end
      for (int i = 0; i < 64; i++) begin
         if (i == 63) push_win(200, 128, 1'b1);
         send((i % 2) ? 228 : 28, 1'b1, (i % 2) ? 127 : -72);
      end
      for (int i = 0; i < 64; i++) begin
         if (i == 63) push_win(200, 128, 1'b1);
         send((i % 2) ? 228 : 28, 1'b1, (i % 2) ? 100 : -100);
      end
      idle(3);
`ifdef VPP_AVG_EN
      check("final_vpp", int'(vpp), 150);
`else
      check("final_vpp", int'(vpp), 200);
`endif
      check("sig_queue_drained", sig_q.size(), 0);
      check("win_queue_drained", win_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vpp_dc_extractor.md
VPP_DC_EXTRACTOR -- requirements
Module: vpp_dc_extractor

Interface
REQ-001 SHALL have parameter WINDOW_POINTS, default 64, samples per measurement window (power of two).
REQ-002 SHALL have parameter LOG2_WINDOW, default 6, log2 of WINDOW_POINTS.
REQ-003 SHALL have parameter MIN_VPP, default 8, minimum Vpp for signal_present.
REQ-004 SHALL have port sample_clk  input  1  sample clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port adc_data  input  8  unsigned raw ADC sample.
REQ-007 SHALL have port adc_valid  input  1  adc_data is valid this edge.
REQ-008 SHALL have port signal_dc_removed  output  8  signed sample minus dc_offset, saturated.
REQ-009 SHALL have port signal_valid  output  1  signal_dc_removed updated this cycle.
REQ-010 SHALL have port vpp  output  8  unsigned peak-to-peak of last completed window.
REQ-011 SHALL have port dc_offset  output  8  unsigned (max+min)/2 of last completed window.
REQ-012 SHALL have port window_done  output  1  one-cycle pulse when vpp/dc_offset update.
REQ-013 SHALL have port stats_valid  output  1  at least one window has completed since reset.
REQ-014 SHALL have port signal_present  output  1  vpp >= MIN_VPP at last window end.

Function
REQ-015 SHALL count valid samples only; adc_valid low freezes counter, min, max and all outputs except the signal_valid and window_done pulses, which drop to 0.
REQ-016 SHALL track running min/max; at window start, min restarts at 255 and max at 0, so the first sample sets both.
REQ-017 SHALL, on the edge capturing the valid sample with count == WINDOW_POINTS-1, register vpp = max'-min' and dc_offset = (max'+min')>>1, using a 9-bit sum; max' and min' include that sample.
REQ-018 SHALL assert window_done for exactly the cycle after the REQ-017 edge, then clear the counter to 0 and reload min/max.
REQ-019 SHALL have a two-state FSM: WARMUP (reset state) -> RUN on the first window end; RUN leaves only on reset.
REQ-020 SHALL hold stats_valid = 0 in WARMUP and 1 in RUN.
REQ-021 SHALL, in RUN, register signal_dc_removed = sat8(adc_data - dc_offset) one cycle after each valid sample, computed in 9-bit signed and clamped to [-128, 127], with signal_valid pulsed.
REQ-022 SHALL, in WARMUP, hold signal_dc_removed = 0 and signal_valid = 0.
REQ-023 SHALL, when a sample coincides with a window-end update, subtract the dc_offset in effect before that update.
REQ-024 SHALL update signal_present only at window end; dc_offset updates regardless of signal_present.

Reset
REQ-025 SHALL on rst_n low immediately clear signal_dc_removed, signal_valid, vpp, dc_offset, window_done, stats_valid, signal_present and counter to 0, set min=255 and max=0, and enter WARMUP.
REQ-026 SHALL discard a partial window on reset mid-window; the next window_done follows WINDOW_POINTS further valid samples.

Configuration
REQ-027 SHALL honour macro VPP_AVG_EN: if defined, vpp is the mean of the last four window Vpp values (10-bit sum >> 2), and history entries reset to 0.
REQ-028 SHALL, without VPP_AVG_EN, output the raw single-window Vpp; signal_present always uses the raw single-window Vpp.

Structure
REQ-029 SHALL place the sample width (8), saturation limits (127/-128) and min/max reload constants (255/0) in a shared package.
REQ-030 SHALL implement min/max tracking in one sub-module, minmax_tracker, with inputs sample, valid and restart and outputs min and max.

Verification
REQ-031 SHALL test: 64 valid samples of 128 -> window_done pulse, vpp=0, dc_offset=128, signal_present=0, stats_valid=1.
REQ-032 SHALL test: alternating 28/228 for two windows -> vpp=200, dc_offset=128; second-window outputs alternate -100/+100.
REQ-033 SHALL test saturation: after a window spanning 0..20 (dc_offset=10), input 255 -> output 127; after a window spanning 235..255 (dc_offset=245), input 0 -> output -128.
REQ-034 SHALL test: adc_valid high one cycle in three -> window_done only after the 64th valid sample, at 192 clocks.
REQ-035 SHALL test: reset asserted at sample 30 of the second window -> all outputs 0 and WARMUP; next window_done after 64 new samples.
REQ-036 SHALL test, with VPP_AVG_EN: window Vpp sequence 100,100,200,200 -> vpp=150 after the fourth window.
